// File: rtl/mem_pkg.sv
// Shared data-memory port definitions: access-mode encoding and byte-mask helpers.
// Imported by the load/store unit, its merge stage and the memory block.
package mem_pkg;

   typedef enum logic [2:0] {
      NONE      = 3'd0,
      BYTE      = 3'd1,
      HALFWORD  = 3'd2,
      WORD      = 3'd3,
      WORDLEFT  = 3'd4,
      WORDRIGHT = 3'd5
   } readWriteModes;

   // Entry n keeps the low n bytes of a word.
   localparam logic [4:0][31:0] BYTE_MASK = {
      32'hFFFF_FFFF,
      32'h00FF_FFFF,
      32'h0000_FFFF,
      32'h0000_00FF,
      32'h0000_0000
   };

   function automatic logic [31:0] low_mask(input logic [2:0] n_bytes);
      logic [2:0] idx;
      idx = (n_bytes > 3'd4) ? 3'd4 : n_bytes;
      return BYTE_MASK[idx];
   endfunction

   function automatic logic [31:0] high_mask(input logic [2:0] n_bytes);
      logic [2:0] keep_low;
      keep_low = (n_bytes > 3'd4) ? 3'd0 : (3'd4 - n_bytes);
      return ~low_mask(keep_low);
   endfunction

   function automatic logic is_access_mode(input logic [2:0] mode);
      return (mode >= 3'd1) && (mode <= 3'd5);
   endfunction

   function automatic logic is_misaligned(input logic [2:0] mode, input logic [1:0] offset);
      return ((mode == HALFWORD) && offset[0]) || ((mode == WORD) && (offset != 2'b00));
   endfunction

endpackage

// File: rtl/lsu_merge.sv
// Combinational lwl/lwr register merge: the memory returns only the loaded bytes,
// zero-filled, and the untouched bytes are taken from the old rt value.
module lsu_merge
   import mem_pkg::*;
(
   input  logic [2:0]  mode,
   input  logic [1:0]  byte_offset,
   input  logic [31:0] mem_rdata,
   input  logic [31:0] rt_old,
   output logic [31:0] merged
);

   logic [2:0] k;

   assign k = {1'b0, byte_offset};

   always_comb begin
      merged = mem_rdata;
      case (mode)
         WORDLEFT:  merged = mem_rdata | (rt_old & low_mask(3'd3 - k));
         WORDRIGHT: merged = mem_rdata | (rt_old & high_mask(k));
         default:   merged = mem_rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Initiator side of the data-memory port: one request at a time, IDLE -> ACCESS -> RESP.
// Optional alignment fault detection is enabled by defining LSU_ALIGN_CHECK_EN.
module load_store_unit
   import mem_pkg::*;
#(
   parameter int unsigned MEM_LATENCY = 1,
   parameter int unsigned ADDR_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_is_store,
   input  logic [2:0]            req_mode,
   input  logic                  req_unsigned,
   input  logic [ADDR_WIDTH-1:0] req_address,
   input  logic [31:0]           req_store_data,
   input  logic [31:0]           req_rt_old,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [31:0]           resp_data,
   output logic                  resp_fault,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [31:0]           mem_data,
   output logic [2:0]            mem_write_mode,
   output logic [2:0]            mem_read_mode,
   output logic                  mem_unsigned_load,
   input  logic [31:0]           mem_data_output
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } lsu_state_t;

   localparam logic [3:0] COUNT_INIT = 4'(MEM_LATENCY - 1);

   lsu_state_t            state_q, state_d;
   logic                  req_ready_q, req_ready_d;
   logic                  resp_valid_q, resp_valid_d;
   logic                  resp_fault_q, resp_fault_d;
   logic [31:0]           resp_data_q, resp_data_d;
   logic [3:0]            count_q, count_d;
   logic                  first_q, first_d;
   logic                  is_store_q, is_store_d;
   logic [2:0]            mode_q, mode_d;
   logic                  unsigned_q, unsigned_d;
   logic [ADDR_WIDTH-1:0] address_q, address_d;
   logic [31:0]           store_data_q, store_data_d;
   logic [31:0]           rt_old_q, rt_old_d;

   logic [31:0]           merged;
   logic                  misaligned;
   logic                  access_en;

`ifdef LSU_ALIGN_CHECK_EN
   assign misaligned = is_misaligned(req_mode, req_address[1:0]);
`else
   assign misaligned = 1'b0;
`endif

   lsu_merge u_merge (
      .mode        (mode_q),
      .byte_offset (address_q[1:0]),
      .mem_rdata   (mem_data_output),
      .rt_old      (rt_old_q),
      .merged      (merged)
   );

   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      first_d      = first_q;
      resp_data_d  = resp_data_q;
      resp_fault_d = resp_fault_q;
      is_store_d   = is_store_q;
      mode_d       = mode_q;
      unsigned_d   = unsigned_q;
      address_d    = address_q;
      store_data_d = store_data_q;
      rt_old_d     = rt_old_q;

      case (state_q)
         IDLE: begin
            if (req_valid && req_ready_q) begin
               is_store_d   = req_is_store;
               mode_d       = req_mode;
               unsigned_d   = req_unsigned;
               address_d    = req_address;
               store_data_d = req_store_data;
               rt_old_d     = req_rt_old;
               count_d      = COUNT_INIT;
               first_d      = 1'b1;
               resp_data_d  = 32'h0;
               resp_fault_d = misaligned;
               state_d      = misaligned ? RESP : ACCESS;
            end
         end
         ACCESS: begin
            first_d = 1'b0;
            if (count_q == 4'd0) begin
               // Stores and non-access modes retire with a zero result.
               resp_data_d = (is_store_q || !is_access_mode(mode_q)) ? 32'h0 : merged;
               state_d     = RESP;
            end else begin
               count_d = count_q - 4'd1;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      req_ready_d  = (state_d == IDLE);
      resp_valid_d = (state_d == RESP);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         req_ready_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_fault_q <= 1'b0;
         resp_data_q  <= 32'h0;
         count_q      <= 4'd0;
         first_q      <= 1'b0;
         is_store_q   <= 1'b0;
         mode_q       <= 3'd0;
         unsigned_q   <= 1'b0;
         address_q    <= '0;
         store_data_q <= 32'h0;
         rt_old_q     <= 32'h0;
      end else begin
         state_q      <= state_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_fault_q <= resp_fault_d;
         resp_data_q  <= resp_data_d;
         count_q      <= count_d;
         first_q      <= first_d;
         is_store_q   <= is_store_d;
         mode_q       <= mode_d;
         unsigned_q   <= unsigned_d;
         address_q    <= address_d;
         store_data_q <= store_data_d;
         rt_old_q     <= rt_old_d;
      end
   end

   // Memory drive is gated by rst so a store caught by reset never writes.
   assign access_en = !rst && (state_q == ACCESS) && is_access_mode(mode_q);

   assign mem_address       = access_en ? address_q : '0;
   assign mem_data          = access_en ? store_data_q : 32'h0;
   assign mem_read_mode     = (access_en && !is_store_q) ? mode_q : 3'(NONE);
   assign mem_write_mode    = (access_en && is_store_q && first_q) ? mode_q : 3'(NONE);
   assign mem_unsigned_load = access_en && !is_store_q && unsigned_q;

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign resp_fault = resp_fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a MEM_LATENCY=1 unit on a byte-addressed memory model
// and a MEM_LATENCY=3 unit on a small word memory for multi-cycle and reset checks.
`timescale 1ns/1ps
module tb_load_store_unit;
   import mem_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        mem_clear;
   logic        req_is_store;
   logic [2:0]  req_mode;
   logic        req_unsigned;
   logic [31:0] req_address;
   logic [31:0] req_store_data;
   logic [31:0] req_rt_old;

   logic        req_valid, req_ready, resp_valid, resp_ready, resp_fault;
   logic [31:0] resp_data, mem_address, mem_data, mem_data_output;
   logic [2:0]  mem_write_mode, mem_read_mode;
   logic        mem_unsigned_load;

   logic        req_valid3, req_ready3, resp_valid3, resp_ready3, resp_fault3;
   logic [31:0] resp_data3, mem_address3, mem_data3, mem_data_output3;
   logic [2:0]  mem_write_mode3, mem_read_mode3;
   logic        mem_unsigned_load3;

   load_store_unit #(.MEM_LATENCY(1), .ADDR_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_is_store(req_is_store), .req_mode(req_mode), .req_unsigned(req_unsigned),
      .req_address(req_address), .req_store_data(req_store_data), .req_rt_old(req_rt_old),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_fault(resp_fault),
      .mem_address(mem_address), .mem_data(mem_data),
      .mem_write_mode(mem_write_mode), .mem_read_mode(mem_read_mode),
      .mem_unsigned_load(mem_unsigned_load), .mem_data_output(mem_data_output)
   );

   load_store_unit #(.MEM_LATENCY(3), .ADDR_WIDTH(32)) dut3 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid3), .req_ready(req_ready3),
      .req_is_store(req_is_store), .req_mode(req_mode), .req_unsigned(req_unsigned),
      .req_address(req_address), .req_store_data(req_store_data), .req_rt_old(req_rt_old),
      .resp_valid(resp_valid3), .resp_ready(resp_ready3), .resp_data(resp_data3), .resp_fault(resp_fault3),
      .mem_address(mem_address3), .mem_data(mem_data3),
      .mem_write_mode(mem_write_mode3), .mem_read_mode(mem_read_mode3),
      .mem_unsigned_load(mem_unsigned_load3), .mem_data_output(mem_data_output3)
   );

   // Byte-addressed memory for the latency-1 unit; lwl/lwr return shifted, zero-filled bytes.
   logic [7:0]  mem1 [0:4095];
   logic [11:0] ra;
   logic [31:0] rword;
   logic [7:0]  rbyte;
   logic [15:0] rhalf;
   int          wr_count1, rd_count1;

   always_comb begin
      ra    = mem_address[11:0];
      rword = {mem1[{ra[11:2], 2'b11}], mem1[{ra[11:2], 2'b10}], mem1[{ra[11:2], 2'b01}], mem1[{ra[11:2], 2'b00}]};
      rbyte = mem1[ra];
      rhalf = {mem1[ra + 12'd1], mem1[ra]};
      mem_data_output = 32'h0;
      case (mem_read_mode)
         3'd1: mem_data_output = mem_unsigned_load ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
         3'd2: mem_data_output = mem_unsigned_load ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
         3'd3: mem_data_output = {mem1[ra + 12'd3], mem1[ra + 12'd2], mem1[ra + 12'd1], mem1[ra]};
         3'd4: mem_data_output = rword << (8 * (3 - int'(ra[1:0])));
         3'd5: mem_data_output = rword >> (8 * int'(ra[1:0]));
         default: mem_data_output = 32'h0;
      endcase
   end

   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < 4096; i++) mem1[i] <= 8'h00;
         wr_count1 <= 0;
         rd_count1 <= 0;
      end else begin
         if (mem_write_mode != 3'd0) begin
            wr_count1 <= wr_count1 + 1;
            case (mem_write_mode)
               3'd1: mem1[mem_address[11:0]] <= mem_data[7:0];
               3'd2: begin
                  mem1[mem_address[11:0]]         <= mem_data[7:0];
                  mem1[mem_address[11:0] + 12'd1] <= mem_data[15:8];
               end
               3'd3: begin
                  mem1[mem_address[11:0]]         <= mem_data[7:0];
                  mem1[mem_address[11:0] + 12'd1] <= mem_data[15:8];
                  mem1[mem_address[11:0] + 12'd2] <= mem_data[23:16];
                  mem1[mem_address[11:0] + 12'd3] <= mem_data[31:24];
               end
               default: ;
            endcase
         end
         if (mem_read_mode != 3'd0) rd_count1 <= rd_count1 + 1;
      end
   end

   // Small word memory for the latency-3 unit, window 0x400..0x40F.
   logic [7:0] mem3 [0:15];
   logic [3:0] a3;
   int         wr_count3;

   always_comb begin
      a3 = {mem_address3[3:2], 2'b00};
      mem_data_output3 = 32'h0;
      if (mem_read_mode3 == 3'd3)
         mem_data_output3 = {mem3[a3 + 4'd3], mem3[a3 + 4'd2], mem3[a3 + 4'd1], mem3[a3]};
   end

   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < 16; i++) mem3[i] <= 8'h00;
         wr_count3 <= 0;
      end else if (mem_write_mode3 != 3'd0) begin
         wr_count3 <= wr_count3 + 1;
         if (mem_write_mode3 == 3'd3) begin
            mem3[a3]        <= mem_data3[7:0];
            mem3[a3 + 4'd1] <= mem_data3[15:8];
            mem3[a3 + 4'd2] <= mem_data3[23:16];
            mem3[a3 + 4'd3] <= mem_data3[31:24];
         end
      end
   end

   logic        use3;
   logic        cur_req_ready, cur_resp_valid, cur_resp_fault;
   logic [31:0] cur_resp_data;

   assign cur_req_ready  = use3 ? req_ready3  : req_ready;
   assign cur_resp_valid = use3 ? resp_valid3 : resp_valid;
   assign cur_resp_data  = use3 ? resp_data3  : resp_data;
   assign cur_resp_fault = use3 ? resp_fault3 : resp_fault;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // Full transaction on the selected unit: present, wait for accept, wait for response, handshake.
   task automatic applyStimulus(input logic unit3, input logic st, input logic [2:0] mode,
                                input logic uns, input logic [31:0] addr, input logic [31:0] sdata,
                                input logic [31:0] rtold, output logic [31:0] data,
                                output logic fault, output int lat);
      int n;
      use3           = unit3;
      req_is_store   = st;
      req_mode       = mode;
      req_unsigned   = uns;
      req_address    = addr;
      req_store_data = sdata;
      req_rt_old     = rtold;
      if (unit3) req_valid3 = 1'b1;
      else       req_valid  = 1'b1;
      #1;
      n = 0;
      while (!cur_req_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("accept_ready", 32'(cur_req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid  = 1'b0;
      req_valid3 = 1'b0;
      lat = 0;
      while (!cur_resp_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      checkOutput("resp_arrived", 32'(cur_resp_valid), 32'd1);
      data  = cur_resp_data;
      fault = cur_resp_fault;
      @(posedge clk); #1;
   endtask

   logic [31:0] d;
   logic        f;
   int          lat;
   int          cnt0;
   int          n_wait;
   logic        seen;

   initial begin
      rst = 1'b1; mem_clear = 1'b1; use3 = 1'b0;
      req_valid = 1'b0; req_valid3 = 1'b0; resp_ready = 1'b1; resp_ready3 = 1'b1;
      req_is_store = 1'b0; req_mode = 3'd0; req_unsigned = 1'b0;
      req_address = 32'h0; req_store_data = 32'h0; req_rt_old = 32'h0;
      @(posedge clk); #1;
      mem_clear = 1'b0;
      @(posedge clk); #1;
      checkOutput("reset_req_ready",  32'(req_ready), 32'd0);
      checkOutput("reset_resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("reset_resp_data",  resp_data, 32'h0);
      checkOutput("reset_resp_fault", 32'(resp_fault), 32'd0);
      checkOutput("reset_mem_wmode",  32'(mem_write_mode), 32'd0);
      checkOutput("reset_mem_rmode",  32'(mem_read_mode), 32'd0);
      checkOutput("reset_mem_addr",   mem_address, 32'h0);
      checkOutput("reset_req_ready3", 32'(req_ready3), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      checkOutput("post_reset_req_ready",  32'(req_ready), 32'd1);
      checkOutput("post_reset_req_ready3", 32'(req_ready3), 32'd1);

      // sw then lw at 0x100
      cnt0 = wr_count1;
      applyStimulus(1'b0, 1'b1, WORD, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, d, f, lat);
      checkOutput("sw_resp_data", d, 32'h0);
      checkOutput("sw_latency", 32'(lat), 32'd1);
      checkOutput("sw_write_count", 32'(wr_count1 - cnt0), 32'd1);
      applyStimulus(1'b0, 1'b0, WORD, 1'b0, 32'h100, 32'h0, 32'h0, d, f, lat);
      checkOutput("lw_data", d, 32'hDEADBEEF);
      checkOutput("lw_latency", 32'(lat), 32'd1);
      checkOutput("lw_fault", 32'(f), 32'd0);

      // Signed and unsigned byte loads
      applyStimulus(1'b0, 1'b1, BYTE, 1'b0, 32'h200, 32'h0000_0080, 32'h0, d, f, lat);
      applyStimulus(1'b0, 1'b0, BYTE, 1'b0, 32'h200, 32'h0, 32'h0, d, f, lat);
      checkOutput("lb_data", d, 32'hFFFF_FF80);
      applyStimulus(1'b0, 1'b0, BYTE, 1'b1, 32'h200, 32'h0, 32'h0, d, f, lat);
      checkOutput("lbu_data", d, 32'h0000_0080);

      // lwl/lwr merges against word 0x11223344 at 0x300
      applyStimulus(1'b0, 1'b1, WORD, 1'b0, 32'h300, 32'h11223344, 32'h0, d, f, lat);
      applyStimulus(1'b0, 1'b0, HALFWORD, 1'b0, 32'h300, 32'h0, 32'h0, d, f, lat);
      checkOutput("lh_data", d, 32'h0000_3344);
      applyStimulus(1'b0, 1'b0, WORDLEFT, 1'b0, 32'h301, 32'h0, 32'hAABBCCDD, d, f, lat);
      checkOutput("lwl_k1", d, 32'h3344CCDD);
      applyStimulus(1'b0, 1'b0, WORDRIGHT, 1'b0, 32'h302, 32'h0, 32'hAABBCCDD, d, f, lat);
      checkOutput("lwr_k2", d, 32'hAABB1122);
      applyStimulus(1'b0, 1'b0, WORDLEFT, 1'b0, 32'h303, 32'h0, 32'hAABBCCDD, d, f, lat);
      checkOutput("lwl_k3", d, 32'h11223344);
      applyStimulus(1'b0, 1'b0, WORDRIGHT, 1'b0, 32'h300, 32'h0, 32'hAABBCCDD, d, f, lat);
      checkOutput("lwr_k0", d, 32'h11223344);
      applyStimulus(1'b0, 1'b0, WORDLEFT, 1'b0, 32'h300, 32'h0, 32'hAABBCCDD, d, f, lat);
      checkOutput("lwl_k0", d, 32'h44BBCCDD);
      applyStimulus(1'b0, 1'b0, WORDRIGHT, 1'b0, 32'h303, 32'h0, 32'hAABBCCDD, d, f, lat);
      checkOutput("lwr_k3", d, 32'hAABBCC11);

      // Unused mode code: no memory access, zero result, normal latency
      cnt0 = rd_count1;
      applyStimulus(1'b0, 1'b0, 3'd6, 1'b0, 32'h100, 32'h0, 32'h0, d, f, lat);
      checkOutput("mode6_data", d, 32'h0);
      checkOutput("mode6_reads", 32'(rd_count1 - cnt0), 32'd0);
      checkOutput("mode6_latency", 32'(lat), 32'd1);

      // Writeback stall with a second request waiting
      use3 = 1'b0;
      resp_ready = 1'b0;
      req_is_store = 1'b0; req_mode = WORD; req_unsigned = 1'b0;
      req_address = 32'h300; req_rt_old = 32'h0; req_valid = 1'b1;
      #1;
      checkOutput("stall_pre_ready", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         checkOutput("stall_resp_valid", 32'(resp_valid), 32'd1);
         checkOutput("stall_resp_data", resp_data, 32'h11223344);
         checkOutput("stall_req_ready", 32'(req_ready), 32'd0);
         @(posedge clk); #1;
      end
      req_address = 32'h100;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      checkOutput("handshake_resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("handshake_req_ready", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      checkOutput("second_accept", 32'(req_ready), 32'd0);
      req_valid = 1'b0;
      n_wait = 0;
      while (!resp_valid && n_wait < 40) begin
         @(posedge clk); #1;
         n_wait++;
      end
      checkOutput("second_resp_data", resp_data, 32'hDEADBEEF);
      @(posedge clk); #1;

      // Misaligned word load
      cnt0 = rd_count1;
      applyStimulus(1'b0, 1'b0, WORD, 1'b0, 32'h102, 32'h0, 32'h0, d, f, lat);
`ifdef LSU_ALIGN_CHECK_EN
      checkOutput("misalign_fault", 32'(f), 32'd1);
      checkOutput("misalign_data", d, 32'h0);
      checkOutput("misalign_reads", 32'(rd_count1 - cnt0), 32'd0);
      checkOutput("misalign_latency", 32'(lat), 32'd0);
`else
      checkOutput("misalign_fault", 32'(f), 32'd0);
      checkOutput("misalign_data", d, 32'h0000DEAD);
      checkOutput("misalign_reads", 32'(rd_count1 - cnt0), 32'd1);
      checkOutput("misalign_latency", 32'(lat), 32'd1);
`endif

      // Latency-3 unit: one write edge over three access cycles
      cnt0 = wr_count3;
      applyStimulus(1'b1, 1'b1, WORD, 1'b0, 32'h404, 32'h12345678, 32'h0, d, f, lat);
      checkOutput("l3_sw_latency", 32'(lat), 32'd3);
      checkOutput("l3_sw_writes", 32'(wr_count3 - cnt0), 32'd1);
      checkOutput("l3_sw_mem", {mem3[7], mem3[6], mem3[5], mem3[4]}, 32'h12345678);
      applyStimulus(1'b1, 1'b0, WORD, 1'b0, 32'h404, 32'h0, 32'h0, d, f, lat);
      checkOutput("l3_lw_data", d, 32'h12345678);
      checkOutput("l3_lw_latency", 32'(lat), 32'd3);
      checkOutput("l3_lw_fault", 32'(f), 32'd0);

      // Reset during the first access cycle of a store
      use3 = 1'b1;
      cnt0 = wr_count3;
      req_is_store = 1'b1; req_mode = WORD; req_unsigned = 1'b0;
      req_address = 32'h400; req_store_data = 32'hCAFEF00D; req_valid3 = 1'b1;
      #1;
      checkOutput("rst_pre_ready3", 32'(req_ready3), 32'd1);
      @(posedge clk); #1;
      checkOutput("rst_first_access_wmode", 32'(mem_write_mode3), 32'd3);
      rst = 1'b1;
      #1;
      checkOutput("rst_write_gated", 32'(mem_write_mode3), 32'd0);
      @(posedge clk); #1;
      req_valid3 = 1'b0;
      @(posedge clk); #1;
      checkOutput("rst_req_ready3", 32'(req_ready3), 32'd0);
      checkOutput("rst_resp_valid3", 32'(resp_valid3), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      checkOutput("rst_release_ready3", 32'(req_ready3), 32'd1);
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         seen = seen | resp_valid3;
         @(posedge clk); #1;
      end
      checkOutput("rst_no_response", 32'(seen), 32'd0);
      checkOutput("rst_no_write", 32'(wr_count3 - cnt0), 32'd0);
      checkOutput("rst_mem_unchanged", {mem3[3], mem3[2], mem3[1], mem3[0]}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
